// File: rtl/mc_pkg.sv
// Shared types for the multicycle MIPS control unit.
// Opcodes, state encodings, control-word bundle.
package mc_pkg;

    localparam int ST_W_DEF = 4;
    localparam int OP_W_DEF = 6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [ST_W_DEF-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // pc_w is unconditional; pc_w_cond is gated by the ALU zero flag
    typedef struct packed {
        logic       pc_w;
        logic       pc_w_cond;
        pc_src_t    pc_src;
        logic       iord;
        logic       mem_r;
        logic       mem_w;
        logic       ir_w;
        logic       mem_to_reg;
        logic       reg_w;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// State -> control word table (pure Moore decode).
// ADDI states are decoded only with MC_CTRL_ADDI_EN defined.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            FETCH: begin
                ctrl.mem_r     = 1'b1;
                ctrl.ir_w      = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
                ctrl.pc_w      = 1'b1;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_BOFF;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                ctrl.mem_r = 1'b1;
                ctrl.iord  = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_w      = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                ctrl.mem_w = 1'b1;
                ctrl.iord  = 1'b1;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                ctrl.reg_w   = 1'b1;
                ctrl.reg_dst = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_ALUOUT;
                ctrl.pc_w_cond = 1'b1;
            end
            JUMP: begin
                ctrl.pc_src = PC_JUMP;
                ctrl.pc_w   = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ADDI_WB: begin
                ctrl.reg_w = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM: state register, next state, zero gating.
// Optional addi support with MC_CTRL_ADDI_EN defined.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int ST_W = ST_W_DEF,
    parameter int OP_W = OP_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [OP_W-1:0] i_opcode,
    input  logic            i_zero,
    output logic            o_pc_w_c,
    output logic [1:0]      o_pc_src,
    output logic            o_iord,
    output logic            o_mem_r,
    output logic            o_mem_w,
    output logic            o_ir_w,
    output logic            o_mem_to_reg,
    output logic            o_reg_w,
    output logic            o_reg_dst,
    output logic            o_alu_src_a,
    output logic [1:0]      o_alu_src_b,
    output logic [1:0]      o_alu_op,
    output logic [ST_W-1:0] o_state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        unique case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                unique case (1'b1)
                    is_mem_op(i_opcode):    state_d = MEM_ADDR;
                    (i_opcode == OP_RTYPE): state_d = EXEC;
                    (i_opcode == OP_BEQ):   state_d = BRANCH;
                    (i_opcode == OP_J):     state_d = JUMP;
`ifdef MC_CTRL_ADDI_EN
                    (i_opcode == OP_ADDI):  state_d = ADDI_EX;
`endif
                    default:                state_d = FETCH;
                endcase
            end
            MEM_ADDR: state_d = (i_opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   state_d = MEM_WB;
            EXEC:     state_d = R_WB;
`ifdef MC_CTRL_ADDI_EN
            ADDI_EX:  state_d = ADDI_WB;
`endif
            // terminal states and any unreachable encoding restart at FETCH
            default:  state_d = FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign o_pc_w_c     = ctrl.pc_w | (ctrl.pc_w_cond & i_zero);
    assign o_pc_src     = ctrl.pc_src;
    assign o_iord       = ctrl.iord;
    assign o_mem_r      = ctrl.mem_r;
    assign o_mem_w      = ctrl.mem_w;
    assign o_ir_w       = ctrl.ir_w;
    assign o_mem_to_reg = ctrl.mem_to_reg;
    assign o_reg_w      = ctrl.reg_w;
    assign o_reg_dst    = ctrl.reg_dst;
    assign o_alu_src_a  = ctrl.alu_src_a;
    assign o_alu_src_b  = ctrl.alu_src_b;
    assign o_alu_op     = ctrl.alu_op;
    assign o_state      = ST_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; expected control words hand-written per state.
// Honours MC_CTRL_ADDI_EN for the addi sequence.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       pc_w_c;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_r;
    logic       mem_w;
    logic       ir_w;
    logic       mem_to_reg;
    logic       reg_w;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [3:0] state;

    int n_chk = 0;
    int n_err = 0;
    int exp_q[$];

    logic [14:0] word;

    mc_control_fsm dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_opcode     (opcode),
        .i_zero       (zero),
        .o_pc_w_c     (pc_w_c),
        .o_pc_src     (pc_src),
        .o_iord       (iord),
        .o_mem_r      (mem_r),
        .o_mem_w      (mem_w),
        .o_ir_w       (ir_w),
        .o_mem_to_reg (mem_to_reg),
        .o_reg_w      (reg_w),
        .o_reg_dst    (reg_dst),
        .o_alu_src_a  (alu_src_a),
        .o_alu_src_b  (alu_src_b),
        .o_alu_op     (alu_op),
        .o_state      (state)
    );

    assign word = {pc_w_c, pc_src, iord, mem_r, mem_w, ir_w,
                   mem_to_reg, reg_w, reg_dst, alu_src_a,
                   alu_src_b, alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {pc_w_c,pc_src,iord,mem_r,mem_w,ir_w,m2r,reg_w,reg_dst,a,b,op}
    function automatic logic [14:0] exp_word(input int st, input logic z);
        case (st)
            0:  return 15'b1_00_0_1_0_1_0_0_0_0_01_00;
            1:  return 15'b0_00_0_0_0_0_0_0_0_0_11_00;
            2:  return 15'b0_00_0_0_0_0_0_0_0_1_10_00;
            3:  return 15'b0_00_1_1_0_0_0_0_0_0_00_00;
            4:  return 15'b0_00_0_0_0_0_1_1_0_0_00_00;
            5:  return 15'b0_00_1_0_1_0_0_0_0_0_00_00;
            6:  return 15'b0_00_0_0_0_0_0_0_0_1_00_10;
            7:  return 15'b0_00_0_0_0_0_0_1_1_0_00_00;
            8:  return {z, 14'b01_0_0_0_0_0_0_0_1_00_01};
            9:  return 15'b1_10_0_0_0_0_0_0_0_0_00_00;
            10: return 15'b0_00_0_0_0_0_0_0_0_1_10_00;
            11: return 15'b0_00_0_0_0_0_0_1_0_0_00_00;
            default: return 15'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input string tag, input int st);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".word"}, 32'(word), 32'(exp_word(st, zero)));
        check({tag, ".rw_excl"}, 32'(mem_r & mem_w), 32'd0);
        check({tag, ".wr_excl"}, 32'(reg_w & mem_w), 32'd0);
    endtask

    // expects to be called while in FETCH; walks exp_q then the return
    task automatic run_seq(input string tag, input logic [5:0] op,
                           input logic z);
        opcode = op;
        zero   = z;
        for (int i = 0; i < exp_q.size(); i++) begin
            check_cycle($sformatf("%s[%0d]", tag, i), exp_q[i]);
            step();
        end
        check({tag, ".ret"}, 32'(state), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 6'h00;
        zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cycle("reset", 0);
        #2 rst_n = 1'b1;

        exp_q = '{0, 1, 2, 3, 4};
        run_seq("lw", 6'h23, 1'b0);

        exp_q = '{0, 1, 2, 5};
        run_seq("sw", 6'h2B, 1'b0);

        exp_q = '{0, 1, 6, 7};
        run_seq("rtype", 6'h00, 1'b0);

        exp_q = '{0, 1, 8};
        run_seq("beq_z1", 6'h04, 1'b1);
        run_seq("beq_z0", 6'h04, 1'b0);

        exp_q = '{0, 1, 9};
        run_seq("j", 6'h02, 1'b0);

        exp_q = '{0, 1};
        run_seq("illegal", 6'h3F, 1'b0);

`ifdef MC_CTRL_ADDI_EN
        exp_q = '{0, 1, 10, 11};
`else
        exp_q = '{0, 1};
`endif
        run_seq("addi", 6'h08, 1'b0);

        // zero flag must track combinationally inside BRANCH
        opcode = 6'h04;
        zero   = 1'b0;
        step();
        step();
        check("beq_tog.state", 32'(state), 32'd8);
        check("beq_tog.z0", 32'(pc_w_c), 32'd0);
        zero = 1'b1;
        #1;
        check("beq_tog.z1", 32'(pc_w_c), 32'd1);
        zero = 1'b0;
        #1;
        check("beq_tog.z0b", 32'(pc_w_c), 32'd0);
        step();
        check("beq_tog.ret", 32'(state), 32'd0);

        // async reset mid-EXEC
        opcode = 6'h00;
        step();
        step();
        check("rst_mid.pre", 32'(state), 32'd6);
        rst_n = 1'b0;
        #1;
        check("rst_mid.state", 32'(state), 32'd0);
        check("rst_mid.pc_w_c", 32'(pc_w_c), 32'd1);
        check("rst_mid.ir_w", 32'(ir_w), 32'd1);
        check("rst_mid.reg_w", 32'(reg_w), 32'd0);
        step();
        check("rst_hold.state", 32'(state), 32'd0);
        check("rst_hold.reg_w", 32'(reg_w), 32'd0);
        #2 rst_n = 1'b1;
        exp_q = '{0, 1, 6, 7};
        run_seq("after_rst", 6'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
